// File: rtl/shift_reg_univ.sv
// Universal shift register: load, logical shift, rotate, increment and clear,
// with a registered serial-out bit, a registered increment-wrap flag and a
// combinational zero flag. All state sits behind an asynchronous active-low reset.
module shift_reg_univ #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             zero,
  output logic             carry
);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROTL  = 3'b100;
  localparam logic [2:0] MODE_ROTR  = 3'b101;
  localparam logic [2:0] MODE_INC   = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_reg, q_next;
  logic             sout_reg, sout_next;
  logic             carry_reg, carry_next;

  // Next-state decode: everything holds unless enabled, and each mode only
  // touches the flags it owns (shift/rotate own SOUT, load/inc/clear own CARRY).
  always_comb begin
    q_next     = q_reg;
    sout_next  = sout_reg;
    carry_next = carry_reg;
    if (en) begin
      case (mode)
        MODE_HOLD: begin
          q_next = q_reg;
        end
        MODE_LOAD: begin
          q_next     = d;
          carry_next = 1'b0;
        end
        MODE_SHL: begin
          q_next    = {q_reg[WIDTH-2:0], sin};
          sout_next = q_reg[WIDTH-1];
        end
        MODE_SHR: begin
          q_next    = {sin, q_reg[WIDTH-1:1]};
          sout_next = q_reg[0];
        end
        MODE_ROTL: begin
          q_next    = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
          sout_next = q_reg[WIDTH-1];
        end
        MODE_ROTR: begin
          q_next    = {q_reg[0], q_reg[WIDTH-1:1]};
          sout_next = q_reg[0];
        end
        MODE_INC: begin
          // Wrap happens exactly when the old value is all ones.
          q_next     = q_reg + ONE;
          carry_next = &q_reg;
        end
        MODE_CLEAR: begin
          q_next     = '0;
          carry_next = 1'b0;
        end
        default: begin
          q_next = q_reg;
        end
      endcase
    end
  end

  // State register with asynchronous reset to the configured value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg     <= RESET_VAL;
      sout_reg  <= 1'b0;
      carry_reg <= 1'b0;
    end else begin
      q_reg     <= q_next;
      sout_reg  <= sout_next;
      carry_reg <= carry_next;
    end
  end

  assign q     = q_reg;
  assign sout  = sout_reg;
  assign carry = carry_reg;
  // Zero flag is taken straight from the register, no extra pipeline stage.
  assign zero  = (q_reg == '0);

endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ: directed operations against an arithmetic model,
// a per-cycle compare process, and hand-computed literal checkpoints.
module tb_shift_reg_univ;

  localparam int W = 8;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, en;
  logic [2:0]   mode;
  logic [W-1:0] d;
  logic         sin;
  logic [W-1:0] q;
  logic         sout, zero, carry;

  logic         rst2_n, en2;
  logic [W-1:0] q2;
  logic         sout2, zero2, carry2;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state as plain integers: value in 0..255, flags 0/1.
  int mq = 0, ms = 0, mc = 0;

  shift_reg_univ #(.WIDTH(W), .RESET_VAL(8'h00)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d), .sin(sin),
    .q(q), .sout(sout), .zero(zero), .carry(carry)
  );

  shift_reg_univ #(.WIDTH(W), .RESET_VAL(8'hA5)) u_dut_a5 (
    .clk(clk), .rst_n(rst2_n), .en(en2), .mode(mode), .d(d), .sin(sin),
    .q(q2), .sout(sout2), .zero(zero2), .carry(carry2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model of one enabled edge, written from the operation definitions as arithmetic.
  task automatic model_step(input int m, input int dd, input int s);
    case (m)
      1: begin mq = dd; mc = 0; end
      2: begin ms = mq / 128; mq = (mq * 2) % 256 + s; end
      3: begin ms = mq % 2;   mq = mq / 2 + s * 128; end
      4: begin ms = mq / 128; mq = (mq * 2) % 256 + mq / 128; end
      5: begin ms = mq % 2;   mq = mq / 2 + (mq % 2) * 128; end
      6: begin mc = (mq == 255) ? 1 : 0; mq = (mq + 1) % 256; end
      7: begin mq = 0; mc = 0; end
      default: ;
    endcase
  endtask

  task automatic model_reset();
    mq = 0; ms = 0; mc = 0;
  endtask

  // Drive one cycle's inputs, let the edge happen, advance the model, settle to the falling edge.
  task automatic op(input bit e, input logic [2:0] m, input logic [7:0] dd, input bit s);
    en = e; mode = m; d = dd; sin = s;
    @(posedge clk);
    if (e && rst_n) model_step(int'(m), int'(dd), int'(s));
    @(negedge clk);
    $display("op en=%0d mode=%0d d=%02h sin=%0d -> q=%02h sout=%0d carry=%0d zero=%0d",
             e, m, dd, s, q, sout, carry, zero);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_q", 64'(q), 64'(mq));
      check("cyc_sout", 64'(sout), 64'(ms));
      check("cyc_carry", 64'(carry), 64'(mc));
      check("cyc_zero", 64'(zero), 64'((mq == 0) ? 1 : 0));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1; rst2_n = 1'b1; en = 1'b0; en2 = 1'b0;
    mode = 3'd0; d = '0; sin = 1'b0;

    // Reset pulse with no clock edge
    #2 rst_n = 1'b0; rst2_n = 1'b0;
    #1;
    model_reset();
    check("rst_q", 64'(q), 64'h00);
    check("rst_sout", 64'(sout), 64'h0);
    check("rst_carry", 64'(carry), 64'h0);
    check("rst_zero", 64'(zero), 64'h1);
    check("rst_a5_q", 64'(q2), 64'hA5);
    check("rst_a5_zero", 64'(zero2), 64'h0);
    check("rst_a5_sout", 64'(sout2), 64'h0);
    check("rst_a5_carry", 64'(carry2), 64'h0);
    #1 rst_n = 1'b1; rst2_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    $display("reset released q=%02h q_a5=%02h", q, q2);

    // First enabled edge after reset on the A5 instance increments from the reset value
    en2 = 1'b1;
    op(1'b0, 3'd6, 8'h00, 1'b0);
    en2 = 1'b0;
    check("a5_inc", 64'(q2), 64'hA6);

    // Load then shift
    op(1'b1, 3'd1, 8'h81, 1'b0); check("load81", 64'(q), 64'h81);
    op(1'b1, 3'd2, 8'h00, 1'b0); check("shl_q", 64'(q), 64'h02); check("shl_sout", 64'(sout), 64'h1);
    op(1'b1, 3'd3, 8'h00, 1'b1); check("shr_q", 64'(q), 64'h81); check("shr_sout", 64'(sout), 64'h0);
    op(1'b1, 3'd0, 8'hFF, 1'b1); check("hold_en1", 64'(q), 64'h81);

    // Rotate
    op(1'b1, 3'd1, 8'h96, 1'b0);
    for (int i = 0; i < 8; i++) op(1'b1, 3'd4, 8'h00, 1'b1);
    check("rotl8", 64'(q), 64'h96);
    op(1'b1, 3'd5, 8'h00, 1'b1); check("rotr_q", 64'(q), 64'h4B); check("rotr_sout", 64'(sout), 64'h0);

    // Increment wrap
    op(1'b1, 3'd1, 8'hFE, 1'b0);
    op(1'b1, 3'd6, 8'h00, 1'b0); check("inc_ff", 64'(q), 64'hFF); check("inc_ff_c", 64'(carry), 64'h0);
    op(1'b1, 3'd6, 8'h00, 1'b0); check("inc_wrap", 64'(q), 64'h00); check("inc_wrap_c", 64'(carry), 64'h1);
    check("inc_wrap_z", 64'(zero), 64'h1);
    for (int i = 0; i < 3; i++) op(1'b0, 3'd7, 8'h55, 1'b1);
    check("hold_carry", 64'(carry), 64'h1);
    op(1'b1, 3'd6, 8'h00, 1'b0); check("inc_01", 64'(q), 64'h01); check("inc_01_c", 64'(carry), 64'h0);

    // Load and clear both drop the carry flag
    op(1'b1, 3'd1, 8'hFF, 1'b0);
    op(1'b1, 3'd6, 8'h00, 1'b0);
    op(1'b1, 3'd1, 8'h10, 1'b0); check("load_clr_c", 64'(carry), 64'h0);
    op(1'b1, 3'd1, 8'hFF, 1'b0);
    op(1'b1, 3'd6, 8'h00, 1'b0);
    op(1'b1, 3'd7, 8'h00, 1'b0); check("clear_clr_c", 64'(carry), 64'h0);

    // Enable hold
    op(1'b1, 3'd1, 8'h81, 1'b0);
    op(1'b1, 3'd2, 8'h00, 1'b0);
    op(1'b1, 3'd1, 8'h3C, 1'b0);
    for (int i = 0; i < 5; i++) op(1'b0, 3'd7, 8'hC3, 1'b1);
    check("en0_q", 64'(q), 64'h3C);
    check("en0_sout", 64'(sout), 64'h1);
    op(1'b1, 3'd7, 8'h00, 1'b0); check("clear_q", 64'(q), 64'h00); check("clear_z", 64'(zero), 64'h1);

    // Asynchronous reset in the middle of a shift sequence
    op(1'b1, 3'd1, 8'hF0, 1'b0);
    op(1'b1, 3'd2, 8'h00, 1'b0); check("shl_e0", 64'(q), 64'hE0);
    op(1'b1, 3'd2, 8'h00, 1'b0); check("shl_c0", 64'(q), 64'hC0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_q", 64'(q), 64'h00);
    check("mid_rst_sout", 64'(sout), 64'h0);
    check("mid_rst_z", 64'(zero), 64'h1);
    en = 1'b1; mode = 3'd6;
    repeat (2) @(negedge clk);
    check("rst_ignores_clk", 64'(q), 64'h00);
    #1 rst_n = 1'b1;
    op(1'b1, 3'd6, 8'h00, 1'b0); check("post_rst_inc", 64'(q), 64'h01);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_reg_univ.md
SHIFT_REG_UNIV -- requirements
Module: shift_reg_univ

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 Parameter RESET_VAL, default 0, WIDTH-bit value loaded into Q on reset.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST_N  input  1  asynchronous active-low reset.
REQ-005 EN  input  1  operation enable; 0 = hold all state.
REQ-006 MODE  input  3  operation select, decoded per REQ-012.
REQ-007 D  input  WIDTH  parallel load data.
REQ-008 SIN  input  1  serial input bit for shift modes.
REQ-009 Q  output  WIDTH  register contents.
REQ-010 SOUT  output  1  registered bit most recently shifted or rotated out.
REQ-011 ZERO  output  1  combinational flag, 1 when Q == 0; CARRY  output  1  registered wrap flag from increment.

Function
REQ-012 MODE decode when EN=1: 000 hold; 001 load Q<=D; 010 shl Q<={Q[W-2:0],SIN}; 011 shr Q<={SIN,Q[W-1:1]}; 100 rotl Q<={Q[W-2:0],Q[W-1]}; 101 rotr Q<={Q[0],Q[W-1:1]}; 110 increment Q<=Q+1 mod 2^WIDTH; 111 synchronous clear Q<=0.
REQ-013 Latency: every operation takes effect at the first rising CLK edge where EN=1; Q is valid immediately after that edge.
REQ-014 EN=0: Q, SOUT and CARRY all hold, regardless of MODE, D and SIN.
REQ-015 SOUT update: shl/rotl -> old Q[W-1]; shr/rotr -> old Q[0]; every other mode -> SOUT holds.
REQ-016 CARRY update: increment -> 1 iff old Q was all ones (wrap to 0), else 0; load and clear -> 0; shift, rotate and hold -> CARRY holds.
REQ-017 ZERO is derived from Q only, with no added register stage.
REQ-018 Rotate preserves the population count of Q; WIDTH consecutive rotates in the same direction restore the original Q.
REQ-019 Width rules: all arithmetic is unsigned WIDTH-bit, with no sign extension; D and Q are the same width.
REQ-020 Inputs are sampled only at the rising CLK edge; changes between edges have no effect.
REQ-021 No X propagation: every MODE code is defined, and outputs stay known once reset has been applied.

Reset
REQ-022 RST_N low immediately (asynchronously) forces Q=RESET_VAL, SOUT=0 and CARRY=0, independent of CLK.
REQ-023 While RST_N=0, CLK edges, EN and MODE are ignored.
REQ-024 Reset asserted mid-operation (e.g., between shifts) discards the in-progress sequence; no partial update is retained.
REQ-025 On deassertion, the first active edge with EN=1 performs a normal operation from the reset state.
REQ-026 ZERO after reset reflects RESET_VAL (1 when RESET_VAL=0).

Verification (WIDTH=8, RESET_VAL=0 unless noted)
REQ-027 Reset: pulse RST_N low with no CLK edge -> Q=0x00, SOUT=0, CARRY=0, ZERO=1; rerun with RESET_VAL=0xA5 -> Q=0xA5, ZERO=0.
REQ-028 Load then shift: load 0x81; shl with SIN=0 -> Q=0x02, SOUT=1; shr with SIN=1 -> Q=0x81, SOUT=0.
REQ-029 Rotate: load 0x96; 8x rotl -> Q=0x96 after the 8th edge; a single rotr from 0x96 -> Q=0x4B, SOUT=0.
REQ-030 Increment wrap: load 0xFE; inc -> Q=0xFF, CARRY=0; inc -> Q=0x00, CARRY=1, ZERO=1; inc -> Q=0x01, CARRY=0.
REQ-031 Enable hold: load 0x3C, then EN=0 with MODE=111 for 5 edges -> Q stays 0x3C and SOUT/CARRY are unchanged; EN=1 with MODE=111 -> Q=0x00.
REQ-032 Async reset mid-sequence: load 0xF0, shl twice, assert RST_N between edges -> Q=0x00 at once with no CLK edge; after release, inc -> Q=0x01.
